// File: rtl/gameio_pkg.sv
// Shared constants for the button event peripheral: address map, button bit
// indices, and event/status word field positions.
package gameio_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned TS_W = 16;

  localparam logic [WORD_W-1:0] ADDR_L    = 32'd3000;
  localparam logic [WORD_W-1:0] ADDR_R    = 32'd4000;
  localparam logic [WORD_W-1:0] ADDR_U    = 32'd5000;
  localparam logic [WORD_W-1:0] ADDR_D    = 32'd6000;
  localparam logic [WORD_W-1:0] ADDR_EVT  = 32'd7000;
  localparam logic [WORD_W-1:0] ADDR_STAT = 32'd7004;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;

  localparam int unsigned EVT_VALID_BIT = 31;
  localparam int unsigned EVT_TS_LSB    = 8;

  localparam int unsigned STAT_OVF_BIT   = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_FULL_BIT  = 2;
  localparam int unsigned STAT_CNT_LSB   = 8;
  localparam int unsigned STAT_CNT_W     = 8;

  function automatic logic [WORD_W-1:0] evt_word(input logic [TS_W-1:0] ts,
                                                 input logic [NUM_BTN-1:0] rise);
    logic [WORD_W-1:0] w;
    w = '0;
    w[EVT_VALID_BIT] = 1'b1;
    w[EVT_TS_LSB +: TS_W] = ts;
    w[NUM_BTN-1:0] = rise;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] status_word(input logic [STAT_CNT_W-1:0] cnt,
                                                    input logic full,
                                                    input logic empty,
                                                    input logic ovf);
    logic [WORD_W-1:0] w;
    w = '0;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    w[STAT_FULL_BIT] = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_OVF_BIT] = ovf;
    return w;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous event FIFO; a pop on a full FIFO frees room for a same-cycle push,
// a pop on an empty FIFO is ignored.
module evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next_c,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop       = pop & ~empty;
  assign do_push      = push & (~full | do_pop);
  assign count_next_c = count + CW'(do_push) - CW'(do_pop);
  assign head_c       = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next_c;
      full  <= (count_next_c == CW'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/btn_event_mmio.sv
// Button peripheral on the data-memory read path: sticky press flags, event FIFO
// and registered load-data mux. Define EVT_TIMESTAMP_EN to stamp events with a cycle count.
module btn_event_mmio
  import gameio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ADDR_L     = gameio_pkg::ADDR_L,
  parameter logic [31:0] ADDR_R     = gameio_pkg::ADDR_R,
  parameter logic [31:0] ADDR_U     = gameio_pkg::ADDR_U,
  parameter logic [31:0] ADDR_D     = gameio_pkg::ADDR_D,
  parameter logic [31:0] ADDR_EVT   = gameio_pkg::ADDR_EVT,
  parameter logic [31:0] ADDR_STAT  = gameio_pkg::ADDR_STAT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic [31:0] mem_addr,
  input  logic        mem_wren,
  input  logic [31:0] ram_q,
  output logic [31:0] q_dmem,
  output logic        evt_pend
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] prev;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] flags;
  logic [NUM_BTN-1:0] clr;
  logic               overflow;
  logic               rd;
  logic               sel_l, sel_r, sel_u, sel_d, sel_evt, sel_stat;
  logic               push, pop_req, stat_rd, ovf_set;
  logic [TS_W-1:0]    ts;
  logic [31:0]        head;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;
  logic               full, empty;
  logic [31:0]        rdata;

  assign btn = {btn_d, btn_u, btn_r, btn_l};
  assign rise = btn & ~prev;
  assign push = |rise;

  always_comb begin
    rd       = ~mem_wren;
    sel_l    = (mem_addr == ADDR_L);
    sel_r    = (mem_addr == ADDR_R);
    sel_u    = (mem_addr == ADDR_U);
    sel_d    = (mem_addr == ADDR_D);
    sel_evt  = (mem_addr == ADDR_EVT);
    sel_stat = (mem_addr == ADDR_STAT);
    clr           = '0;
    clr[BTN_L]    = rd & sel_l;
    clr[BTN_R]    = rd & sel_r;
    clr[BTN_U]    = rd & sel_u;
    clr[BTN_D]    = rd & sel_d;
    pop_req       = rd & sel_evt;
    stat_rd       = rd & sel_stat;
    // A full FIFO is never empty, so a pop request always frees the slot.
    ovf_set       = push & full & ~pop_req;
  end

`ifdef EVT_TIMESTAMP_EN
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end
`else
  assign ts = '0;
`endif

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .pop          (pop_req),
    .din          (evt_word(ts, rise)),
    .head_c       (head),
    .count        (count),
    .count_next_c (count_next),
    .full         (full),
    .empty        (empty)
  );

  // Edge history tracks the buttons in reset too, so a held button yields no event.
  always_ff @(posedge clock) begin
    prev <= btn;
  end

  // Set wins over a same-cycle clear for both flags and overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags    <= '0;
      overflow <= 1'b0;
    end else begin
      flags    <= (flags & ~clr) | rise;
      overflow <= (overflow & ~stat_rd) | ovf_set;
    end
  end

  always_comb begin
    rdata = ram_q;
    if (rd) begin
      if (sel_l)         rdata = {31'b0, flags[BTN_L]};
      else if (sel_r)    rdata = {31'b0, flags[BTN_R]};
      else if (sel_u)    rdata = {31'b0, flags[BTN_U]};
      else if (sel_d)    rdata = {31'b0, flags[BTN_D]};
      else if (sel_evt)  rdata = empty ? 32'h0 : head;
      else if (sel_stat) rdata = status_word(STAT_CNT_W'(count), full, empty, overflow);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem   <= '0;
      evt_pend <= 1'b0;
    end else begin
      q_dmem   <= rdata;
      evt_pend <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_btn_event_mmio.sv
// Directed bench for btn_event_mmio: flags, event FIFO ordering, overflow and read mux.
module tb_btn_event_mmio;

  localparam logic [31:0] A_L    = 32'd3000;
  localparam logic [31:0] A_R    = 32'd4000;
  localparam logic [31:0] A_U    = 32'd5000;
  localparam logic [31:0] A_D    = 32'd6000;
  localparam logic [31:0] A_EVT  = 32'd7000;
  localparam logic [31:0] A_STAT = 32'd7004;
  localparam logic [31:0] A_IDLE = 32'd100;

  logic        clock;
  logic        reset;
  logic [3:0]  btn;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] ram_q;
  logic [31:0] q_dmem;
  logic        evt_pend;
  logic [31:0] d;
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  btn_event_mmio dut (
    .clock    (clock),
    .reset    (reset),
    .btn_l    (btn[0]),
    .btn_r    (btn[1]),
    .btn_u    (btn[2]),
    .btn_d    (btn[3]),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .ram_q    (ram_q),
    .q_dmem   (q_dmem),
    .evt_pend (evt_pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] evt_mask(input logic [31:0] w);
`ifdef EVT_TIMESTAMP_EN
    return w & 32'hFF00_00FF;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] data);
    mem_addr = a;
    mem_wren = 1'b0;
    @(posedge clock);
    #1;
    data = q_dmem;
    mem_addr = A_IDLE;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    tick();
    btn[b] = 1'b0;
    tick();
    if (exp_q.size() < 8) exp_q.push_back(32'h8000_0000 | (32'h1 << b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    btn = 4'b0100;
    mem_addr = A_IDLE;
    mem_wren = 1'b0;
    ram_q = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_q_dmem", q_dmem, 32'h0);
    check("rst_evt_pend", {31'b0, evt_pend}, 32'h0);

    // Button held through reset must not produce an event
    reset = 1'b0;
    tick();
    rd(A_STAT, d); check("held_stat", d, 32'h0000_0002);
    btn = 4'b0000;
    tick();

    // Single press: sticky flag read and clear, event pop
    btn[0] = 1'b1;
    tick();
    check("pend_after_press", {31'b0, evt_pend}, 32'h1);
    rd(A_L, d); check("flag_l_set", d, 32'h1);
    rd(A_L, d); check("flag_l_clr", d, 32'h0);
    btn[0] = 1'b0;
    rd(A_EVT, d); check("pop_l", evt_mask(d), 32'h8000_0001);
    check("pend_drained", {31'b0, evt_pend}, 32'h0);
    rd(A_EVT, d); check("pop_empty", d, 32'h0);

    // Simultaneous presses form one entry
    btn = 4'b1010;
    tick();
    btn = 4'b0000;
    rd(A_EVT, d); check("pop_rd", evt_mask(d), 32'h8000_000A);
    rd(A_EVT, d); check("pop_empty2", d, 32'h0);
    rd(A_R, d); check("flag_r", d, 32'h1);
    rd(A_D, d); check("flag_d", d, 32'h1);
    rd(A_U, d); check("flag_u_clear", d, 32'h0);

    // Rise and clear in the same cycle: read sees old value, flag ends set
    btn[2] = 1'b1;
    rd(A_U, d); check("flag_u_same_cycle", d, 32'h0);
    rd(A_U, d); check("flag_u_set_wins", d, 32'h1);
    btn[2] = 1'b0;
    rd(A_EVT, d); check("pop_u", evt_mask(d), 32'h8000_0004);

    // Ten presses into an 8-deep FIFO
    for (int i = 0; i < 10; i++) press(i % 4);
    rd(A_STAT, d); check("stat_full_ovf", d, 32'h0000_0805);
    rd(A_STAT, d); check("stat_ovf_cleared", d, 32'h0000_0804);
    for (int i = 0; i < 8; i++) begin
      rd(A_EVT, d);
      check($sformatf("order_pop%0d", i), evt_mask(d), exp_q.pop_front());
    end
    rd(A_STAT, d); check("stat_empty", d, 32'h0000_0002);

    // Full FIFO with push and pop in the same cycle: nothing dropped
    for (int i = 0; i < 8; i++) press((i + 1) % 4);
    btn[0] = 1'b1;
    mem_addr = A_EVT;
    tick();
    d = q_dmem;
    mem_addr = A_IDLE;
    btn[0] = 1'b0;
    check("full_pushpop_head", evt_mask(d), exp_q.pop_front());
    exp_q.push_back(32'h8000_0001);
    rd(A_STAT, d); check("full_pushpop_stat", d, 32'h0000_0804);

    // Overflow and status read in the same cycle: overflow stays set
    btn[1] = 1'b1;
    rd(A_STAT, d); check("ovf_same_cycle_rd", d, 32'h0000_0804);
    btn[1] = 1'b0;
    rd(A_STAT, d); check("ovf_held", d, 32'h0000_0805);
    rd(A_STAT, d); check("ovf_clr2", d, 32'h0000_0804);
    for (int i = 0; i < 8; i++) begin
      rd(A_EVT, d);
      check($sformatf("drain_pop%0d", i), evt_mask(d), exp_q.pop_front());
    end

    // Unmapped read passes RAM data; writes to mapped addresses are ignored
    ram_q = 32'h0000_1234;
    rd(A_IDLE, d); check("ram_passthru", d, 32'h0000_1234);
    mem_addr = A_L;
    mem_wren = 1'b1;
    ram_q = 32'h0000_ABCD;
    tick();
    check("write_returns_ram", q_dmem, 32'h0000_ABCD);
    mem_wren = 1'b0;
    mem_addr = A_IDLE;
    rd(A_L, d); check("flag_l_after_write", d, 32'h1);
    rd(A_L, d); check("flag_l_cleared", d, 32'h0);
    press(3);
    mem_addr = A_EVT;
    mem_wren = 1'b1;
    tick();
    mem_wren = 1'b0;
    mem_addr = A_IDLE;
    check("write_evt_no_pop", {31'b0, evt_pend}, 32'h1);
    rd(A_EVT, d); check("pop_after_write", evt_mask(d), exp_q.pop_front());

    // Reset mid-operation discards pending state
    press(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("midrst_pend", {31'b0, evt_pend}, 32'h0);
    rd(A_STAT, d); check("midrst_stat", d, 32'h0000_0002);
    rd(A_L, d); check("midrst_flag", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
